// File: rtl/tamagotchi_pkg.sv
// Shared encodings between controlador_estados and controlador_atributos:
// one-hot estado codes and the attribute width/range.
package tamagotchi_pkg;

  localparam int ATTR_W = 8;

  typedef logic [ATTR_W-1:0] atributo_t;

  localparam atributo_t ATTR_MAX = 8'd255;

  localparam logic [3:0] IDLE       = 4'b0000;
  localparam logic [3:0] DORMINDO   = 4'b0001;
  localparam logic [3:0] COMENDO    = 4'b0010;
  localparam logic [3:0] DANDO_AULA = 4'b0100;
  localparam logic [3:0] MORTO      = 4'b1000;

endpackage

// File: rtl/atributo_saturado.sv
// One attribute register: on enable adds inc_i then subtracts dec_i, clamping to [0, ATTR_MAX].
// Single-cycle update; no backpressure, the enable is the only qualifier.
module atributo_saturado
  import tamagotchi_pkg::*;
#(
  parameter int VALOR_INICIAL = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  atributo_t inc_i,
  input  atributo_t dec_i,
  output atributo_t valor_o
);

  atributo_t         valor_q, valor_d;
  logic [ATTR_W:0]   soma;
  atributo_t         soma_sat;

  // The carry bit of the 9-bit sum flags overflow past ATTR_MAX.
  always_comb begin
    soma     = {1'b0, valor_q} + {1'b0, inc_i};
    soma_sat = soma[ATTR_W] ? ATTR_MAX : soma[ATTR_W-1:0];
    valor_d  = valor_q;
    if (en_i) begin
      valor_d = (soma_sat < dec_i) ? '0 : soma_sat - dec_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_q <= ATTR_W'(VALOR_INICIAL);
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor_o = valor_q;

endmodule

// File: rtl/controlador_atributos.sv
// Periodic saturating update of fome/felicidade/sono driven by the controller's one-hot estado.
// Updates every TICK_CICLOS edges; tick marks the first cycle of new values; no backpressure.
module controlador_atributos
  import tamagotchi_pkg::*;
#(
  parameter int TICK_CICLOS   = 65536,
  parameter int INC           = 8,
  parameter int DEC           = 1,
  parameter int VALOR_INICIAL = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] estado,
  output logic [7:0] fome,
  output logic [7:0] felicidade,
  output logic [7:0] sono,
  output logic       tick
);

  localparam int                CNT_W   = $clog2(TICK_CICLOS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_CICLOS - 1);
  localparam atributo_t         INC_A   = ATTR_W'(INC);
  localparam atributo_t         DEC_A   = ATTR_W'(DEC);
  localparam atributo_t         DEC2_A  = ATTR_W'(2 * DEC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             upd;
  logic             en;
  atributo_t        inc_fome, inc_feli, inc_sono;
  atributo_t        dec_fome, dec_feli, dec_sono;

  assign upd   = (cnt_q == CNT_MAX);
  assign cnt_d = upd ? '0 : cnt_q + CNT_W'(1);

  // estado is used directly on the update edge; illegal codes decay like IDLE.
  always_comb begin
    en       = upd;
    inc_fome = '0;
    inc_feli = '0;
    inc_sono = '0;
    dec_fome = DEC_A;
    dec_feli = DEC_A;
    dec_sono = DEC_A;
    case (estado)
      COMENDO: begin
        inc_fome = INC_A;
        dec_fome = '0;
      end
      DORMINDO: begin
        inc_sono = INC_A;
        dec_sono = '0;
      end
      DANDO_AULA: begin
        inc_feli = INC_A;
        dec_feli = '0;
        dec_fome = DEC2_A;
        dec_sono = DEC2_A;
      end
      MORTO: begin
        en = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= upd;
    end
  end

  atributo_saturado #(.VALOR_INICIAL(VALOR_INICIAL)) u_fome (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .inc_i   (inc_fome),
    .dec_i   (dec_fome),
    .valor_o (fome)
  );

  atributo_saturado #(.VALOR_INICIAL(VALOR_INICIAL)) u_felicidade (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .inc_i   (inc_feli),
    .dec_i   (dec_feli),
    .valor_o (felicidade)
  );

  atributo_saturado #(.VALOR_INICIAL(VALOR_INICIAL)) u_sono (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .inc_i   (inc_sono),
    .dec_i   (dec_sono),
    .valor_o (sono)
  );

  assign tick = tick_q;

endmodule

// File: tb/tb_controlador_atributos.sv
// Directed bench: a table of per-update-period vectors plus hand sequences for
// mid-period estado glitches and asynchronous reset.
module tb_controlador_atributos;

  logic       clk;
  logic       rst_n;
  logic [3:0] estado;
  logic [7:0] fome, felicidade, sono;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  controlador_atributos #(
    .TICK_CICLOS  (4),
    .INC          (8),
    .DEC          (1),
    .VALOR_INICIAL(255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .estado     (estado),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] est;
    int         reps;
    logic [7:0] f;
    logic [7:0] h;
    logic [7:0] s;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_attrs(input string name, input logic [7:0] f, input logic [7:0] h,
                             input logic [7:0] s);
    check({name, ".fome"}, fome, f);
    check({name, ".felicidade"}, felicidade, h);
    check({name, ".sono"}, sono, s);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pf, ph, ps;

    // Start values are 255/255/255; each row is the estado held across 'reps'
    // update periods and the attribute values after the last of them.
    tbl[0]  = '{IDLE_C(),      1, 8'd254, 8'd254, 8'd254};
    tbl[1]  = '{IDLE_C(),      1, 8'd253, 8'd253, 8'd253};
    tbl[2]  = '{IDLE_C(),      1, 8'd252, 8'd252, 8'd252};
    tbl[3]  = '{4'b0010,       1, 8'd255, 8'd251, 8'd251};
    tbl[4]  = '{4'b0010,     250, 8'd255, 8'd1,   8'd1  };
    tbl[5]  = '{4'b0100,       1, 8'd253, 8'd9,   8'd0  };
    tbl[6]  = '{4'b0100,       1, 8'd251, 8'd17,  8'd0  };
    tbl[7]  = '{IDLE_C(),      1, 8'd250, 8'd16,  8'd0  };
    tbl[8]  = '{4'b0001,       1, 8'd249, 8'd15,  8'd8  };
    tbl[9]  = '{4'b1000,       3, 8'd249, 8'd15,  8'd8  };
    tbl[10] = '{IDLE_C(),      1, 8'd248, 8'd14,  8'd7  };
    tbl[11] = '{4'b1111,       1, 8'd247, 8'd13,  8'd6  };
    tbl[12] = '{4'b0110,       1, 8'd246, 8'd12,  8'd5  };

    rst_n  = 1'b0;
    estado = 4'b0000;
    step(2);
    check_attrs("reset", 8'd255, 8'd255, 8'd255);
    check("reset.tick", {7'b0, tick}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pf = 8'd255; ph = 8'd255; ps = 8'd255;
    for (int i = 0; i < 13; i++) begin
      estado = tbl[i].est;
      for (int r = 0; r < tbl[i].reps; r++) begin
        step(3);
        if (r == 0) check_attrs($sformatf("v%0d.mid", i), pf, ph, ps);
        check($sformatf("v%0d.mid.tick", i), {7'b0, tick}, 8'd0);
        step(1);
        check($sformatf("v%0d.tick", i), {7'b0, tick}, 8'd1);
      end
      check_attrs($sformatf("v%0d", i), tbl[i].f, tbl[i].h, tbl[i].s);
      pf = tbl[i].f; ph = tbl[i].h; ps = tbl[i].s;
    end

    // estado glitches between 0011 and 0000 mid-period; only the update-edge value counts.
    estado = 4'b0011; step(1);
    estado = 4'b0000; step(1);
    estado = 4'b0011; step(1);
    check_attrs("glitch.mid", 8'd246, 8'd12, 8'd5);
    step(1);
    check("glitch.tick", {7'b0, tick}, 8'd1);
    check_attrs("glitch", 8'd245, 8'd11, 8'd4);
    estado = 4'b0000;

    // Reset with the counter at 2: outputs must drop without a clock edge.
    step(2);
    rst_n = 1'b0;
    #1;
    check_attrs("arst", 8'd255, 8'd255, 8'd255);
    check("arst.tick", {7'b0, tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_attrs("arst.rel3", 8'd255, 8'd255, 8'd255);
    check("arst.rel3.tick", {7'b0, tick}, 8'd0);
    step(1);
    check("arst.rel4.tick", {7'b0, tick}, 8'd1);
    check_attrs("arst.rel4", 8'd254, 8'd254, 8'd254);

    // Reset while tick is high must clear it immediately.
    rst_n = 1'b0;
    #1;
    check("arst_tick.tick", {7'b0, tick}, 8'd0);
    check_attrs("arst_tick", 8'd255, 8'd255, 8'd255);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("arst_tick.rel3.tick", {7'b0, tick}, 8'd0);
    step(1);
    check("arst_tick.rel4.tick", {7'b0, tick}, 8'd1);
    check_attrs("arst_tick.rel4", 8'd254, 8'd254, 8'd254);
    step(1);
    check("arst_tick.rel5.tick", {7'b0, tick}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [3:0] IDLE_C();
    return 4'b0000;
  endfunction

endmodule
